// File: rtl/regfile_bypass.sv
// regfile_bypass: numRegs x width register file with two combinational read
// ports and one write port. A read of the register being written this cycle
// returns writeData before the edge (write-through bypass). Storage is
// assembled from single-bit dff cells, each fed by a hold mux. err flags
// unknown control/data inputs and never gates storage.

// Single-bit storage cell with asynchronous active-high clear.
module regfile_bypass_dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Capture d on the rising edge; rst clears immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

module regfile_bypass #(
  parameter int width   = 16,
  parameter int numRegs = 8,
  localparam int IW     = (numRegs > 1) ? $clog2(numRegs) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    read1RegSel,
  input  logic [IW-1:0]    read2RegSel,
  input  logic [IW-1:0]    writeRegSel,
  input  logic [width-1:0] writeData,
  input  logic             writeEn,
  output logic [width-1:0] read1Data,
  output logic [width-1:0] read2Data,
  output logic             err
);

  // The index space is padded to a power of two so any select value addresses
  // a defined entry; entries past numRegs read as zero.
  localparam int DEPTH = 1 << IW;

  logic [DEPTH-1:0][width-1:0] q;
  logic [width-1:0]            wd_x;
  logic                        wd_all_x;

  genvar r, b;
  generate
    for (r = 0; r < DEPTH; r++) begin : g_reg
      if (r < numRegs) begin : g_live
        logic             we;
        logic [width-1:0] d;
        logic [width-1:0] cell_q;

        assign we = writeEn && (writeRegSel == IW'(r));

        // Hold mux: an if (rather than ?:) keeps the register holding when
        // the strobe is unknown instead of smearing X into the cells.
        always_comb begin
          d = cell_q;
          if (we) d = writeData;
        end

        for (b = 0; b < width; b++) begin : g_bit
          regfile_bypass_dff u_cell (
            .clk (clk),
            .rst (rst),
            .d   (d[b]),
            .q   (cell_q[b])
          );
        end

        assign q[r] = cell_q;
      end else begin : g_pad
        assign q[r] = '0;
      end
    end

    // Per-bit unknown detect on writeData; only an all-X word raises err.
    for (b = 0; b < width; b++) begin : g_wdx
      assign wd_x[b] = $isunknown(writeData[b]);
    end
  endgenerate

  assign wd_all_x = &wd_x;

  // Read port 1: selected register, overridden by the in-flight write.
  always_comb begin
    read1Data = q[read1RegSel];
    if (writeEn && (read1RegSel == writeRegSel)) read1Data = writeData;
  end

  // Read port 2: same rule, evaluated independently of port 1.
  always_comb begin
    read2Data = q[read2RegSel];
    if (writeEn && (read2RegSel == writeRegSel)) read2Data = writeData;
  end

  // Input sanity flag; purely observational, never feeds storage.
  always_comb begin
    err = $isunknown(writeEn)     || $isunknown(read1RegSel) ||
          $isunknown(read2RegSel) || $isunknown(writeRegSel) ||
          (writeEn && wd_all_x);
  end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed + randomized bench for regfile_bypass. A plain array holds the
// architectural register contents; expected reads follow the write-through
// rule directly from that array and the current write request.
module tb_regfile_bypass;

  localparam int W = 16;
  localparam int N = 8;

  logic         clk, rst;
  logic [2:0]   read1RegSel, read2RegSel, writeRegSel;
  logic [W-1:0] writeData, read1Data, read2Data;
  logic         writeEn, err;

  logic [W-1:0] mdl [N];
  int tests = 0;
  int fails = 0;

  regfile_bypass #(.width(W), .numRegs(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .read1RegSel (read1RegSel),
    .read2RegSel (read2RegSel),
    .writeRegSel (writeRegSel),
    .writeData   (writeData),
    .writeEn     (writeEn),
    .read1Data   (read1Data),
    .read2Data   (read2Data),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  function automatic logic [W-1:0] exp_rd(input logic [2:0] s);
    if (writeEn === 1'b1 && s == writeRegSel) return writeData;
    return mdl[s];
  endfunction

  function automatic logic exp_err();
    logic allx = 1'b1;
    for (int i = 0; i < W; i++) if (!$isunknown(writeData[i])) allx = 1'b0;
    return $isunknown(writeEn) || $isunknown(read1RegSel) ||
           $isunknown(read2RegSel) || $isunknown(writeRegSel) ||
           (writeEn === 1'b1 && allx);
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    chk({tag, " rd1"}, read1Data, exp_rd(read1RegSel));
    chk({tag, " rd2"}, read2Data, exp_rd(read2RegSel));
    chk({tag, " err"}, {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, exp_err()});
  endtask

  task automatic set(input logic we, input logic [2:0] ws, input logic [W-1:0] wd,
                     input logic [2:0] r1, input logic [2:0] r2);
    writeEn = we; writeRegSel = ws; writeData = wd;
    read1RegSel = r1; read2RegSel = r2;
    #1;
  endtask

  // Commit the model at the edge using the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (rst !== 1'b1 && writeEn === 1'b1) mdl[writeRegSel] = writeData;
    #2;
  endtask

  task automatic clear_mdl();
    for (int i = 0; i < N; i++) mdl[i] = '0;
  endtask

  // Sweep every register through both ports with no write pending.
  task automatic check_all(input string tag);
    writeEn = 1'b0;
    for (int i = 0; i < N; i++) begin
      read1RegSel = 3'(i);
      read2RegSel = 3'(N - 1 - i);
      #1;
      chk({tag, " rd1"}, read1Data, mdl[i]);
      chk({tag, " rd2"}, read2Data, mdl[N-1-i]);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_mdl();
    #3;
    set(1'b0, 3'd0, '0, 3'd0, 3'd1);
    check_ports("reset");
    check_all("reset_all");
    tick();
    tick();
    rst = 1'b0;

    // First write right after release is accepted.
    set(1'b1, 3'd1, 16'hA5A5, 3'd1, 3'd0);
    check_ports("first_wr_bypass");
    tick();
    set(1'b0, 3'd0, '0, 3'd1, 3'd0);
    chk("first_wr_visible", read1Data, 16'hA5A5);

    // Write/read visibility one cycle after the edge.
    set(1'b1, 3'd5, 16'h1234, 3'd0, 3'd0);
    tick();
    set(1'b0, 3'd0, '0, 3'd5, 3'd4);
    chk("wr5_rd1", read1Data, 16'h1234);
    chk("wr5_rd2_r4", read2Data, 16'h0000);
    check_ports("wr5_model");

    // Bypass on both ports, then stored value after the edge.
    set(1'b1, 3'd2, 16'h00AA, 3'd0, 3'd0);
    tick();
    set(1'b1, 3'd2, 16'h5555, 3'd2, 3'd2);
    chk("byp_rd1", read1Data, 16'h5555);
    chk("byp_rd2", read2Data, 16'h5555);
    tick();
    set(1'b0, 3'd0, '0, 3'd2, 3'd2);
    chk("byp_post_rd1", read1Data, 16'h5555);
    chk("byp_post_rd2", read2Data, 16'h5555);

    // Back-to-back writes to R7; R6 untouched.
    set(1'b1, 3'd6, 16'h0666, 3'd0, 3'd0);
    tick();
    set(1'b1, 3'd7, 16'h0001, 3'd0, 3'd0);
    tick();
    set(1'b1, 3'd7, 16'h0002, 3'd7, 3'd6);
    check_ports("b2b_second_bypass");
    tick();
    set(1'b0, 3'd0, '0, 3'd7, 3'd6);
    chk("b2b_r7", read1Data, 16'h0002);
    chk("b2b_r6", read2Data, 16'h0666);

    // Hold: writeEn low with all-ones data for ten cycles.
    for (int c = 0; c < 10; c++) begin
      set(1'b0, 3'($urandom_range(0, 7)), 16'hFFFF,
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      check_ports("hold_cyc");
      tick();
    end
    check_all("hold_all");

    // Randomized traffic; same-register collisions are forced often.
    for (int c = 0; c < 300; c++) begin
      logic [2:0] ws;
      ws = 3'($urandom_range(0, 7));
      set(1'($urandom_range(0, 1)), ws, 16'($urandom),
          ($urandom_range(0, 3) == 0) ? ws : 3'($urandom_range(0, 7)),
          ($urandom_range(0, 3) == 0) ? ws : 3'($urandom_range(0, 7)));
      check_ports("rand");
      tick();
    end
    check_all("rand_all");

    // err behaviour.
    set(1'b0, 3'd1, 16'h0F0F, 3'd2, 3'd3);
    chk("err_known", {{(W-1){1'b0}}, err}, '0);
    writeEn = 1'bx;
    #1;
    chk("err_we_x", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, exp_err()});
    tick();
    set(1'b0, 3'd1, 16'h0F0F, 3'd2, 3'd3);
    read1RegSel = 3'bxxx;
    #1;
    chk("err_sel_x", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, exp_err()});
    tick();
    set(1'b1, 3'd0, '0, 3'd2, 3'd3);
    writeData = 'x;
    #1;
    chk("err_wd_x", {{(W-1){1'b0}}, err}, {{(W-1){1'b0}}, exp_err()});
    tick();

    // Asynchronous reset between edges, then a write held through reset.
    set(1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0);
    tick();
    set(1'b0, 3'd0, '0, 3'd3, 3'd3);
    chk("pre_rst_r3", read1Data, 16'hBEEF);
    #5;
    rst = 1'b1;
    clear_mdl();
    #1;
    chk("async_rst_r3", read1Data, 16'h0000);
    set(1'b1, 3'd4, 16'h1111, 3'd4, 3'd5);
    check_ports("rst_bypass");
    tick();
    rst = 1'b0;
    check_all("post_rst_all");
    set(1'b1, 3'd0, 16'hCAFE, 3'd1, 3'd1);
    tick();
    set(1'b0, 3'd0, '0, 3'd0, 3'd4);
    chk("post_rst_first_wr", read1Data, 16'hCAFE);
    chk("post_rst_r4", read2Data, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
